// File: rtl/wvfm_lut_loader.sv
`timescale 1ns/1ps
// Streams host bytes into the caster waveform LUT: buffers packed bytes, unpacks them
// to one 2-bit entry per cycle, and writes only while the scan engine is held idle.
module wvfm_lut_loader #(
    parameter int unsigned LUT_ENTRIES = 16384,
    parameter int unsigned ADDR_W      = 14,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              scan_busy,
    output logic              lut_hold,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr_wr,
    output logic [1:0]        ram_wr,
    output logic              loading,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned NBYTES = LUT_ENTRIES / 4;
    localparam int unsigned BYTE_W = $clog2(NBYTES + 1);
    localparam int unsigned ENT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wp;
    logic [PTR_W-1:0]   r_rp;
    logic [CNT_W-1:0]   r_cnt;
    logic [BYTE_W-1:0]  r_bytes;
    logic [7:0]         r_sh;
    logic [1:0]         r_slot;
    logic               r_up_vld;
    logic [ENT_W-1:0]   r_entry;
    logic               r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [1:0]         r_ram_wr;
    logic               r_hold;
    logic               r_loading;
    logic               r_done;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic               w_abort;
    logic               w_grant;
    logic               w_issue;
    logic               w_last_vis;
    logic [7:0]         w_head;
    logic [1:0]         w_entry;

    always_comb begin
        w_full     = (r_cnt == CNT_W'(FIFO_DEPTH));
        w_empty    = (r_cnt == '0);
        w_ready    = r_loading && !w_full && (r_bytes < BYTE_W'(NBYTES)) && !load_start;
        w_push     = wr_valid && w_ready;
        w_head     = r_mem[r_rp];
        w_abort    = (r_state == ST_WRITE) && scan_busy && !load_start;
        w_grant    = ((r_state == ST_WRITE) || (r_state == ST_DRAIN)) && !scan_busy &&
                     !load_start && (r_entry < ENT_W'(LUT_ENTRIES));
        w_issue    = w_grant && (r_up_vld || !w_empty);
        // Bypass the FIFO head straight out when the unpacker is empty so there is no bubble
        w_pop      = w_issue && (!r_up_vld || ((r_slot == 2'd3) && !w_empty));
        w_entry    = r_up_vld ? r_sh[1:0] : w_head[1:0];
        w_last_vis = r_ram_we && (r_ram_addr == ADDR_W'(LUT_ENTRIES - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (load_start) w_next = ST_DRAIN;
            ST_DRAIN: if (load_start) w_next = ST_DRAIN;
                      else if (!scan_busy) w_next = ST_WRITE;
            ST_WRITE: if (load_start) w_next = ST_DRAIN;
                      else if (scan_busy) w_next = ST_IDLE;
                      else if (w_last_vis) w_next = ST_DONE;
            ST_DONE:  if (load_start) w_next = ST_DRAIN;
                      else w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_cnt      <= '0;
            r_bytes    <= '0;
            r_sh       <= '0;
            r_slot     <= '0;
            r_up_vld   <= 1'b0;
            r_entry    <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_wr   <= '0;
        end else if (load_start || w_abort) begin
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_bytes  <= '0;
            r_slot   <= '0;
            r_up_vld <= 1'b0;
            r_entry  <= '0;
            r_ram_we <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp    <= r_wp + PTR_W'(1);
                r_bytes <= r_bytes + BYTE_W'(1);
            end
            if (w_pop) r_rp <= r_rp + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
            r_ram_we <= w_issue;
            if (w_issue) begin
                r_ram_addr <= r_entry[ADDR_W-1:0];
                r_ram_wr   <= w_entry;
                r_entry    <= r_entry + ENT_W'(1);
                if (!r_up_vld) begin
                    r_sh     <= {2'b00, w_head[7:2]};
                    r_slot   <= 2'd1;
                    r_up_vld <= 1'b1;
                end else if (r_slot == 2'd3) begin
                    if (!w_empty) begin
                        r_sh   <= w_head;
                        r_slot <= 2'd0;
                    end else begin
                        r_up_vld <= 1'b0;
                    end
                end else begin
                    r_sh   <= {2'b00, r_sh[7:2]};
                    r_slot <= r_slot + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold    <= 1'b0;
            r_loading <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_hold    <= (w_next != ST_IDLE);
            r_loading <= (w_next != ST_IDLE);
            r_done    <= (w_next == ST_DONE);
            if (load_start)   r_err <= 1'b0;
            else if (w_abort) r_err <= 1'b1;
        end
    end

    // A write strobe already launched is withdrawn if the scan engine grabs the port
    assign ram_we      = r_ram_we & ~scan_busy;
    assign ram_addr_wr = r_ram_addr;
    assign ram_wr      = r_ram_wr;
    assign wr_ready    = w_ready;
    assign lut_hold    = r_hold;
    assign loading     = r_loading;
    assign load_done   = r_done;
    assign load_err    = r_err;

endmodule

// File: tb/tb_wvfm_lut_loader.sv
`timescale 1ns/1ps
// Directed bench for wvfm_lut_loader on a 16-entry LUT with a 2-byte FIFO.
module tb_wvfm_lut_loader;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic       scan_busy;
    logic       lut_hold;
    logic       ram_we;
    logic [3:0] ram_addr_wr;
    logic [1:0] ram_wr;
    logic       loading;
    logic       load_done;
    logic       load_err;

    wvfm_lut_loader #(.LUT_ENTRIES(16), .ADDR_W(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .scan_busy(scan_busy),
        .lut_hold(lut_hold), .ram_we(ram_we), .ram_addr_wr(ram_addr_wr),
        .ram_wr(ram_wr), .loading(loading), .load_done(load_done), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cnum = 0;
    int n_acc, n_done, n_stall, n_hold_lo, n_overlap;
    int first_we, last_we, first_acc;
    int q_a[$];
    int q_d[$];
    int s_we, s_addr, s_wr, s_hold, s_done, s_rdy, s_load, s_err;
    int pw, perr, phold;
    logic [7:0] b [5];

    typedef struct {
        bit         ls;
        bit         v;
        logic [7:0] d;
        bit         we;
        int         addr;
        int         wr;
        bit         hold;
        bit         done;
        bit         rdy;
    } vec_t;
    vec_t tv [21];
    int   seq [16] = '{0,1,2,3,3,2,1,0,3,3,3,3,0,0,0,0};

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Samples outputs mid-cycle, then lets the next rising edge consume the inputs
    task automatic cyc();
        @(negedge clk);
        s_we = int'(ram_we); s_addr = int'(ram_addr_wr); s_wr = int'(ram_wr);
        s_hold = int'(lut_hold); s_done = int'(load_done); s_rdy = int'(wr_ready);
        s_load = int'(loading); s_err = int'(load_err);
        if (ram_we) begin
            q_a.push_back(int'(ram_addr_wr));
            q_d.push_back(int'(ram_wr));
            if (first_we < 0) first_we = cnum;
            last_we = cnum;
        end
        if (load_done) n_done++;
        if (load_done && ram_we) n_overlap++;
        if (!lut_hold) n_hold_lo++;
        if (wr_valid && !wr_ready && n_acc < 4) n_stall++;
        if (wr_valid && wr_ready) begin
            if (n_acc == 0) first_acc = cnum;
            n_acc++;
        end
        @(posedge clk);
        #1;
        cnum++;
    endtask

    task automatic clear_stats();
        n_acc = 0; n_done = 0; n_stall = 0; n_hold_lo = 0;
        first_we = -1; last_we = -1; first_acc = -1;
        q_a.delete(); q_d.delete();
    endtask

    task automatic start();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic drive(input int gap, input int blo, input int bhi, input int stop_wr,
                         input int lim);
        int idx, wt, acc0, d0;
        idx = 0; wt = 0; d0 = n_done;
        for (int c = 0; c < lim; c++) begin
            scan_busy = (c >= blo && c < bhi);
            if (idx < 5 && wt == 0) begin
                wr_valid = 1'b1; wr_data = b[idx];
            end else begin
                wr_valid = 1'b0; wr_data = 8'h00;
            end
            acc0 = n_acc;
            cyc();
            if (c == blo) pw = s_we;
            if (c == bhi) begin perr = s_err; phold = s_hold; end
            if (n_acc != acc0) begin idx++; wt = gap; end
            else if (wt > 0) wt--;
            if (n_done != d0 || q_a.size() >= stop_wr) break;
        end
        wr_valid = 1'b0;
        scan_busy = 1'b0;
    endtask

    task automatic check_writes(input string nm, input int n);
        int errs;
        logic [7:0] by;
        errs = 0;
        check({nm, "_count"}, q_a.size(), n);
        for (int i = 0; i < n && i < q_a.size(); i++) begin
            by = b[i / 4];
            if (q_a[i] != i || q_d[i] != int'((by >> (2 * (i % 4))) & 8'h03)) errs++;
        end
        check({nm, "_data"}, errs, 0);
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3; b[4] = b4;
    endtask

    initial begin
        int t0;
        rst_n = 1'b0; load_start = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; scan_busy = 1'b0;
        n_overlap = 0; pw = 0; perr = 0; phold = 0;
        clear_stats();
        #1;
        cyc(); cyc();
        check("rst_we", s_we, 0);
        check("rst_hold", s_hold, 0);
        check("rst_loading", s_load, 0);
        check("rst_ready", s_rdy, 0);
        check("rst_err", s_err, 0);
        rst_n = 1'b1;
        cyc();

        // Back-to-back load; cycle-exact expectations including FIFO backpressure
        for (int k = 0; k < 21; k++)
            tv[k] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0};
        tv[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 8'hE4, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 8'h1B, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};
        for (int k = 3; k < 19; k++) begin
            tv[k].we = 1'b1; tv[k].addr = k - 3; tv[k].wr = seq[k - 3];
        end
        tv[3].v = 1'b1; tv[3].d = 8'hFF; tv[3].rdy = 1'b1;
        tv[4].v = 1'b1; tv[4].d = 8'h00;
        tv[5].v = 1'b1; tv[5].d = 8'h00;
        tv[6].v = 1'b1; tv[6].d = 8'h00; tv[6].rdy = 1'b1;
        tv[19].done = 1'b1;
        tv[20].hold = 1'b0;
        for (int k = 0; k < 21; k++) begin
            load_start = tv[k].ls; wr_valid = tv[k].v; wr_data = tv[k].d;
            cyc();
            check($sformatf("t1_we_k%0d", k), s_we, int'(tv[k].we));
            check($sformatf("t1_rdy_k%0d", k), s_rdy, int'(tv[k].rdy));
            check($sformatf("t1_hold_k%0d", k), s_hold, int'(tv[k].hold));
            check($sformatf("t1_done_k%0d", k), s_done, int'(tv[k].done));
            if (tv[k].we) begin
                check($sformatf("t1_addr_k%0d", k), s_addr, tv[k].addr);
                check($sformatf("t1_wr_k%0d", k), s_wr, tv[k].wr);
            end
        end
        load_start = 1'b0; wr_valid = 1'b0;
        cyc(); cyc();

        // Scan engine busy at load start for 20 cycles
        set_bytes(8'h5A, 8'hC3, 8'h0F, 8'h96, 8'h11);
        clear_stats();
        scan_busy = 1'b1;
        t0 = cnum;
        start();
        n_hold_lo = 0;
        drive(0, 0, 19, 99, 80);
        check("t2_first_we", first_we, t0 + 21);
        check_writes("t2_wr", 16);
        check("t2_done", n_done, 1);
        check("t2_hold_lo", n_hold_lo, 0);
        check("t2_err", s_err, 0);
        cyc(); cyc();

        // wr_valid held high with a fifth byte pending
        set_bytes(8'h39, 8'hA7, 8'h4E, 8'hD2, 8'h6C);
        clear_stats();
        start();
        drive(0, 0, 0, 99, 60);
        wr_valid = 1'b1; wr_data = b[4];
        for (int i = 0; i < 5; i++) cyc();
        wr_valid = 1'b0;
        check("t3_handshakes", n_acc, 4);
        check("t3_full_stalls", n_stall, 2);
        check_writes("t3_wr", 16);
        check("t3_done", n_done, 1);
        cyc();

        // Ten idle host cycles between bytes
        set_bytes(8'h87, 8'h2D, 8'hF0, 8'h5C, 8'h00);
        clear_stats();
        start();
        n_hold_lo = 0;
        drive(10, 0, 0, 99, 120);
        check_writes("t4_wr", 16);
        check("t4_latency", first_we - first_acc, 2);
        check("t4_idle_in_span", (last_we - first_we + 1) - 16, 21);
        check("t4_hold_lo", n_hold_lo, 0);
        check("t4_done", n_done, 1);
        cyc();

        // Scan engine grabs the port mid-write
        set_bytes(8'hE4, 8'h1B, 8'hFF, 8'h00, 8'h00);
        clear_stats();
        start();
        drive(0, 7, 8, 99, 20);
        check("t5_masked_we", pw, 0);
        check("t5_err", perr, 1);
        check("t5_hold", phold, 0);
        check("t5_writes_before", q_a.size(), 5);
        check("t5_no_done", n_done, 0);
        check("t5_loading", s_load, 0);
        set_bytes(8'h93, 8'h6B, 8'h1E, 8'hC5, 8'h00);
        clear_stats();
        start();
        check("t5_err_on_start", s_err, 1);
        drive(0, 0, 0, 99, 60);
        check("t5_err_cleared", s_err, 0);
        check_writes("t5_wr", 16);
        check("t5_done2", n_done, 1);
        cyc();

        // Restart mid-load, then reset mid-load
        set_bytes(8'h4B, 8'hE1, 8'h72, 8'h3D, 8'h00);
        clear_stats();
        start();
        drive(0, 0, 0, 7, 40);
        check("t6_pre_writes", q_a.size(), 7);
        t0 = n_acc;
        wr_valid = 1'b1; wr_data = 8'hAA;
        start();
        wr_valid = 1'b0;
        check("t6_rdy_on_restart", s_rdy, 0);
        check("t6_no_accept", n_acc, t0);
        cyc();
        check("t6_hold_kept", s_hold, 1);
        clear_stats();
        drive(0, 0, 0, 5, 40);
        check_writes("t6_restart", 5);
        rst_n = 1'b0;
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        check("t6_rst_we", s_we, 0);
        check("t6_rst_addr", s_addr, 0);
        check("t6_rst_wr", s_wr, 0);
        check("t6_rst_hold", s_hold, 0);
        check("t6_rst_loading", s_load, 0);
        check("t6_rst_done", s_done, 0);
        check("t6_rst_err", s_err, 0);
        check("t6_rst_ready", s_rdy, 0);

        check("done_we_overlap", n_overlap, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
